// File: rtl/mux_n_stream_pkg.sv
// rtl/mux_n_stream_pkg.sv - shared constants and lock-state type for the N-channel stream mux
package mux_n_stream_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/mux_n_stream_if.sv
// rtl/mux_n_stream_if.sv - producer-side and consumer-side stream signals of the N-channel mux
interface mux_n_stream_if #(
  parameter int N_CH = 4,
  parameter int DW   = 8
);
  localparam int CW = $clog2(N_CH);

  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]    in_valid;
  logic [N_CH-1:0]    in_last;
  logic [N_CH-1:0]    in_ready;
  logic [DW-1:0]      out_data;
  logic [CW-1:0]      out_chan;
  logic               out_valid;
  logic               out_ready;

  // slave: the mux itself; master: whatever drives the producers and consumer
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_n_stream_rr_arbiter_n.sv
// rtl/mux_n_stream_rr_arbiter_n.sv - combinational round-robin search from a pointer, wrapping at N_CH-1
module rr_arbiter_n #(
  parameter int N_CH = 4,
  parameter int CW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] valid,
  input  logic [CW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [CW-1:0]   idx
);

  int  c;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N_CH; i++) begin
      c = int'(ptr) + i;
      if (c >= N_CH) c = c - N_CH;
      if (!found && valid[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = CW'(c);
      end
    end
  end

endmodule

// File: rtl/mux_n_stream.sv
// rtl/mux_n_stream.sv - N-channel stream mux, fixed or round-robin select, registered output
// Packet lock (hold grant until in_last) is built when MUX_N_STREAM_PKT_LOCK_EN is defined.
module mux_n_stream
  import mux_n_stream_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [$clog2(N_CH)-1:0] sel,
  mux_n_stream_if.slave           s
);

  localparam int CW = $clog2(N_CH);

  logic [CW-1:0]   ptr_q;
  logic [N_CH-1:0] rr_grant;
  logic [CW-1:0]   rr_idx;
  logic [N_CH-1:0] grant;
  logic [CW-1:0]   gidx;
  logic [DW-1:0]   data_sel;
  logic            load_en;
  logic            xfer;
  logic            locked;
  logic [CW-1:0]   lock_ch;

  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic [CW-1:0]   out_chan_q;

  rr_arbiter_n #(.N_CH(N_CH), .CW(CW)) u_arb (
    .valid (s.in_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // a locked packet overrides both mode and sel
  always_comb begin
    grant = '0;
    gidx  = '0;
    if (locked) begin
      if (s.in_valid[lock_ch]) begin
        grant[lock_ch] = 1'b1;
        gidx           = lock_ch;
      end
    end else if (mode == MODE_RR) begin
      grant = rr_grant;
      gidx  = rr_idx;
    end else if (int'(sel) < N_CH && s.in_valid[sel]) begin
      grant[sel] = 1'b1;
      gidx       = sel;
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) data_sel = s.in_data[i*DW +: DW];
    end
  end

  assign load_en    = !out_valid_q || s.out_ready;
  assign xfer       = load_en && (|grant);
  assign s.in_ready = (rst_n && load_en) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= data_sel;
      out_chan_q  <= gidx;
      ptr_q       <= (int'(gidx) == N_CH - 1) ? '0 : gidx + CW'(1);
    end else if (s.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_chan  = out_chan_q;

`ifdef MUX_N_STREAM_PKT_LOCK_EN
  lock_state_t state_q, state_d;
  logic [CW-1:0] lock_ch_q, lock_ch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer && !s.in_last[gidx]) begin
          state_d   = ST_LOCKED;
          lock_ch_d = gidx;
        end
      end
      ST_LOCKED: begin
        if (xfer && s.in_last[lock_ch_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign locked  = (state_q == ST_LOCKED);
  assign lock_ch = lock_ch_q;
`else
  logic unused_last;

  assign unused_last = ^s.in_last;
  assign locked      = 1'b0;
  assign lock_ch     = '0;
`endif

endmodule

// File: tb/tb_mux_n_stream.sv
// tb/tb_mux_n_stream.sv - directed checks of mux_n_stream (N_CH=4 main instance, N_CH=3 for out-of-range sel)
module tb_mux_n_stream;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [1:0] sel;
  logic       mode3;
  logic [1:0] sel3;
  int         errors;
  int         checks;
  int         exp6 [5];

  mux_n_stream_if #(.N_CH(4), .DW(8)) m ();
  mux_n_stream_if #(.N_CH(3), .DW(8)) b ();

  mux_n_stream #(.N_CH(4), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .sel   (sel),
    .s     (m)
  );

  mux_n_stream #(.N_CH(3), .DW(8)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode3),
    .sel   (sel3),
    .s     (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    mode = 1'b0;
    sel = 2'd0;
    mode3 = 1'b0;
    sel3 = 2'd0;
    m.in_data = '0;
    m.in_valid = '0;
    m.in_last = '1;
    m.out_ready = 1'b1;
    b.in_data = {8'h32, 8'h31, 8'h30};
    b.in_valid = '0;
    b.in_last = '1;
    b.out_ready = 1'b1;

    // reset state, with a valid input that must not be accepted
    @(negedge clk);
    m.in_valid = 4'b0001;
    #1;
    check("rst_out_valid", m.out_valid, 0);
    check("rst_out_data", m.out_data, 0);
    check("rst_out_chan", m.out_chan, 0);
    check("rst_in_ready", m.in_ready, 0);
    m.in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: fixed select of channel 2
    sel = 2'd2;
    m.in_valid = 4'b0100;
    m.in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    #1;
    check("t1_in_ready", m.in_ready, 4'b0100);
    @(negedge clk);
    check("t1_out_valid", m.out_valid, 1);
    check("t1_out_data", m.out_data, 8'hA5);
    check("t1_out_chan", m.out_chan, 2);
    m.in_valid = 4'b0000;
    @(negedge clk);
    check("t1_valid_drop", m.out_valid, 0);

    // 2: round-robin over all four channels
    do_reset();
    mode = 1'b1;
    m.in_valid = 4'b1111;
    m.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_in_ready", m.in_ready, 32'(1) << (i % 4));
      @(negedge clk);
      check("t2_out_chan", m.out_chan, i % 4);
      check("t2_out_data", m.out_data, 8'h10 + (i % 4));
    end

    // 3: round-robin skips idle channels 0 and 2
    do_reset();
    m.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_in_ready", m.in_ready, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      @(negedge clk);
      check("t3_out_chan", m.out_chan, (i % 2 == 0) ? 1 : 3);
    end

    // 4: backpressure holds the beat, then resumes with the next channel
    do_reset();
    m.in_valid = 4'b1111;
    @(negedge clk);
    check("t4_first_chan", m.out_chan, 0);
    m.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_stall_in_ready", m.in_ready, 0);
      @(negedge clk);
      check("t4_stall_valid", m.out_valid, 1);
      check("t4_stall_chan", m.out_chan, 0);
      check("t4_stall_data", m.out_data, 8'h10);
    end
    m.out_ready = 1'b1;
    #1;
    check("t4_resume_in_ready", m.in_ready, 4'b0010);
    @(negedge clk);
    check("t4_resume_chan", m.out_chan, 1);
    check("t4_resume_data", m.out_data, 8'h11);

    // 5a: out-of-range select on a 3-channel mux gives no grant
    m.in_valid = 4'b0000;
    sel3 = 2'd3;
    b.in_valid = 3'b111;
    #1;
    check("t5_oor_in_ready", b.in_ready, 0);
    @(negedge clk);
    check("t5_oor_out_valid", b.out_valid, 0);
    sel3 = 2'd2;
    #1;
    check("t5_inr_in_ready", b.in_ready, 3'b100);
    @(negedge clk);
    check("t5_inr_out_chan", b.out_chan, 2);
    check("t5_inr_out_data", b.out_data, 8'h32);
    b.in_valid = 3'b000;

    // 5b: asynchronous reset mid-stream clears output and pointer
    do_reset();
    m.in_valid = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    check("t5_pre_chan", m.out_chan, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", m.out_valid, 0);
    check("t5_async_data", m.out_data, 0);
    check("t5_async_in_ready", m.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_ptr_in_ready", m.in_ready, 4'b0001);
    @(negedge clk);
    check("t5_ptr_chan", m.out_chan, 0);

`ifdef MUX_N_STREAM_PKT_LOCK_EN
    // 6: a three-beat packet on channel 1 holds the grant
    do_reset();
    m.in_valid = 4'b0001;
    m.in_last = 4'b1111;
    @(negedge clk);
    m.in_valid = 4'b0111;
    exp6 = '{1, 1, 1, 2, 0};
    for (int i = 0; i < 5; i++) begin
      m.in_last = (i == 2) ? 4'b1111 : 4'b1101;
      @(negedge clk);
      check("t6_lock_chan", m.out_chan, exp6[i]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
